// File: rtl/block_pkg.sv
// Shared definitions for the falling-block controller.
// Contents: controller state enum and default playfield/block geometry.
package block_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FALLING = 2'd1,
        FIXED   = 2'd2
    } state_e;

    localparam int DEF_WIDTH       = 32;
    localparam int DEF_HEIGHT      = 32;
    localparam int DEF_STEP        = 32;
    localparam int DEF_FALL_PERIOD = 30;
    localparam int DEF_X_START     = 304;
    localparam int DEF_Y_START     = 0;
    localparam int DEF_X_MIN       = 0;
    localparam int DEF_X_MAX       = 1024;
    localparam int DEF_FLOOR_Y     = 768;

endpackage

// File: rtl/btn_pending.sv
// Rising-edge latch for one debounced button.
// Ports:
//   clk_in, rst_in  - clock, synchronous active-low reset
//   level           - debounced button level
//   consume         - clears the pending flag
//   enable          - allows new edges to be latched
//   pending         - a rising edge has been seen and not yet consumed
module btn_pending (
    input  logic clk_in,
    input  logic rst_in,
    input  logic level,
    input  logic consume,
    input  logic enable,
    output logic pending
);

    logic prev_q, prev_d;
    logic pend_q, pend_d;

    always_comb begin
        prev_d = level;
        pend_d = pend_q;
        if (consume) pend_d = 1'b0;
        // A fresh edge in the consuming cycle is kept for the next frame.
        if (enable && level && !prev_q) pend_d = 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            // History follows the pin so a button held through reset is not an edge.
            prev_q <= level;
            pend_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
            pend_q <= pend_d;
        end
    end

    assign pending = pend_q;

endmodule

// File: rtl/block_controller.sv
// Falling-block position controller.
// Ports:
//   clk_in, rst_in        - clock, synchronous active-low reset
//   nf_in                 - new-frame pulse; position only changes on these
//   start_in              - spawn request (ignored while falling)
//   left_in, right_in     - level buttons, one move per press
//   drop_in               - level button, gravity every frame while held
//   x_out, y_out          - block top-left corner
//   is_fixed              - block has landed
//   landed_out            - one-cycle pulse on landing
module block_controller
    import block_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int HEIGHT      = DEF_HEIGHT,
    parameter int STEP        = DEF_STEP,
    parameter int FALL_PERIOD = DEF_FALL_PERIOD,
    parameter int X_START     = DEF_X_START,
    parameter int Y_START     = DEF_Y_START,
    parameter int X_MIN       = DEF_X_MIN,
    parameter int X_MAX       = DEF_X_MAX,
    parameter int FLOOR_Y     = DEF_FLOOR_Y
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        nf_in,
    input  logic        start_in,
    input  logic        left_in,
    input  logic        right_in,
    input  logic        drop_in,
    output logic [10:0] x_out,
    output logic [9:0]  y_out,
    output logic        is_fixed,
    output logic        landed_out
);

    // All geometry math is 12-bit so no intermediate sum wraps.
    localparam logic [11:0] W12     = 12'(WIDTH);
    localparam logic [11:0] H12     = 12'(HEIGHT);
    localparam logic [11:0] STEP12  = 12'(STEP);
    localparam logic [11:0] XMIN12  = 12'(X_MIN);
    localparam logic [11:0] XMAX12  = 12'(X_MAX);
    localparam logic [11:0] FLOOR12 = 12'(FLOOR_Y);
    localparam logic [10:0] XS      = 11'(X_START);
    localparam logic [9:0]  YS      = 10'(Y_START);
    localparam logic [7:0]  FP_LAST = 8'(FALL_PERIOD - 1);

    state_e      state_q, state_d;
    logic [10:0] x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        landed_q, landed_d;
    logic        fixed_q, fixed_d;

    logic        pend_l, pend_r;
    logic        consume;
    logic        btn_en;
    logic [11:0] x12, y12, x_mv, y_mv;

    assign btn_en = (state_q == FALLING);
    assign x12    = {1'b0, x_q};
    assign y12    = {2'b0, y_q};

    btn_pending u_left (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .level   (left_in),
        .consume (consume),
        .enable  (btn_en),
        .pending (pend_l)
    );

    btn_pending u_right (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .level   (right_in),
        .consume (consume),
        .enable  (btn_en),
        .pending (pend_r)
    );

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        cnt_d    = cnt_q;
        landed_d = 1'b0;
        consume  = 1'b0;
        x_mv     = x12;
        y_mv     = y12;

        case (state_q)
            IDLE, FIXED: begin
                if (start_in) begin
                    x_d     = XS;
                    y_d     = YS;
                    cnt_d   = 8'd0;
                    consume = 1'b1;
                    state_d = FALLING;
                end
            end
            FALLING: begin
                if (nf_in) begin
                    consume = 1'b1;
                    // Opposite presses in one frame cancel out.
                    if (pend_l && !pend_r)
                        x_mv = (x12 >= XMIN12 + STEP12) ? x12 - STEP12 : XMIN12;
                    else if (pend_r && !pend_l)
                        x_mv = (x12 + W12 + STEP12 <= XMAX12) ? x12 + STEP12 : XMAX12 - W12;
                    x_d = x_mv[10:0];

                    if (drop_in || cnt_q == FP_LAST) begin
                        cnt_d = 8'd0;
                        if (y12 + H12 + STEP12 < FLOOR12) begin
                            y_mv = y12 + STEP12;
                        end else begin
                            y_mv     = FLOOR12 - H12;
                            landed_d = 1'b1;
                            state_d  = FIXED;
                        end
                        y_d = y_mv[9:0];
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        fixed_d = (state_d == FIXED);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q  <= IDLE;
            x_q      <= XS;
            y_q      <= YS;
            cnt_q    <= 8'd0;
            landed_q <= 1'b0;
            fixed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            cnt_q    <= cnt_d;
            landed_q <= landed_d;
            fixed_q  <= fixed_d;
        end
    end

    assign x_out      = x_q;
    assign y_out      = y_q;
    assign is_fixed   = fixed_q;
    assign landed_out = landed_q;

endmodule

// File: tb/tb_block_controller.sv
module tb_block_controller;

    logic        clk_in = 1'b0;
    logic        rst_in, nf_in, start_in, left_in, right_in, drop_in;
    logic [10:0] x_out;
    logic [9:0]  y_out;
    logic        is_fixed, landed_out;

    int tests_run = 0;
    int tests_failed = 0;

    block_controller dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .nf_in      (nf_in),
        .start_in   (start_in),
        .left_in    (left_in),
        .right_in   (right_in),
        .drop_in    (drop_in),
        .x_out      (x_out),
        .y_out      (y_out),
        .is_fixed   (is_fixed),
        .landed_out (landed_out)
    );

    always #5 clk_in = ~clk_in;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic do_reset();
        @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
    endtask

    task automatic do_start();
        @(negedge clk_in);
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
    endtask

    task automatic frame();
        @(negedge clk_in);
        nf_in = 1'b1;
        @(negedge clk_in);
        nf_in = 1'b0;
    endtask

    // dir: 0 = left, 1 = right; press, release, then one frame
    task automatic press(input bit dir);
        @(negedge clk_in);
        if (dir) right_in = 1'b1; else left_in = 1'b1;
        @(negedge clk_in);
        right_in = 1'b0;
        left_in  = 1'b0;
        frame();
    endtask

    task automatic test_reset();
        left_in = 1'b1;
        do_reset();
        tests_run++;
        if (x_out !== 11'd304 || y_out !== 10'd0 || is_fixed !== 1'b0 || landed_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state x=%0d y=%0d fix=%0b land=%0b exp 304/0/0/0", x_out, y_out, is_fixed, landed_out);
        end
        do_start();
        frame();
        tests_run++;
        if (x_out !== 11'd304) begin
            tests_failed++;
            $display("FAIL held_through_reset x=%0d exp 304", x_out);
        end
        left_in = 1'b0;
    endtask

    task automatic test_gravity();
        do_reset();
        do_start();
        for (int i = 1; i <= 30; i++) begin
            frame();
            tests_run++;
            if (y_out !== ((i == 30) ? 10'd32 : 10'd0)) begin
                tests_failed++;
                $display("FAIL gravity_frame%0d y=%0d exp %0d", i, y_out, (i == 30) ? 32 : 0);
            end
        end
    endtask

    task automatic test_left_hold();
        do_reset();
        do_start();
        @(negedge clk_in);
        left_in = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            frame();
            tests_run++;
            if (x_out !== 11'd272) begin
                tests_failed++;
                $display("FAIL left_hold_frame%0d x=%0d exp 272", i, x_out);
            end
        end
        left_in = 1'b0;
    endtask

    task automatic test_clamp();
        do_reset();
        do_start();
        for (int i = 0; i < 9; i++) press(1'b0);
        tests_run++;
        if (x_out !== 11'd16) begin
            tests_failed++;
            $display("FAIL left_to_16 x=%0d exp 16", x_out);
        end
        press(1'b0);
        tests_run++;
        if (x_out !== 11'd0) begin
            tests_failed++;
            $display("FAIL left_clamp_16 x=%0d exp 0", x_out);
        end
        press(1'b0);
        tests_run++;
        if (x_out !== 11'd0) begin
            tests_failed++;
            $display("FAIL left_clamp_0 x=%0d exp 0", x_out);
        end
        for (int i = 0; i < 30; i++) press(1'b1);
        tests_run++;
        if (x_out !== 11'd960) begin
            tests_failed++;
            $display("FAIL right_to_960 x=%0d exp 960", x_out);
        end
        press(1'b1);
        tests_run++;
        if (x_out !== 11'd992) begin
            tests_failed++;
            $display("FAIL right_960 x=%0d exp 992", x_out);
        end
        press(1'b1);
        tests_run++;
        if (x_out !== 11'd992) begin
            tests_failed++;
            $display("FAIL right_clamp x=%0d exp 992", x_out);
        end
    endtask

    task automatic test_drop();
        do_reset();
        do_start();
        @(negedge clk_in);
        drop_in = 1'b1;
        for (int i = 1; i <= 22; i++) begin
            frame();
            tests_run++;
            if (y_out !== 10'(32 * i) || landed_out !== 1'b0 || is_fixed !== 1'b0) begin
                tests_failed++;
                $display("FAIL drop_frame%0d y=%0d land=%0b fix=%0b exp %0d/0/0", i, y_out, landed_out, is_fixed, 32 * i);
            end
        end
        // Right press lands together with the final gravity step.
        @(negedge clk_in);
        right_in = 1'b1;
        @(negedge clk_in);
        right_in = 1'b0;
        frame();
        tests_run++;
        if (y_out !== 10'd736 || landed_out !== 1'b1 || is_fixed !== 1'b1 || x_out !== 11'd336) begin
            tests_failed++;
            $display("FAIL drop_land y=%0d land=%0b fix=%0b x=%0d exp 736/1/1/336", y_out, landed_out, is_fixed, x_out);
        end
        @(negedge clk_in);
        tests_run++;
        if (landed_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL land_pulse_width land=%0b exp 0", landed_out);
        end
        press(1'b0);
        for (int i = 0; i < 3; i++) frame();
        tests_run++;
        if (y_out !== 10'd736 || x_out !== 11'd336 || is_fixed !== 1'b1 || landed_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL fixed_hold y=%0d x=%0d fix=%0b land=%0b exp 736/336/1/0", y_out, x_out, is_fixed, landed_out);
        end
        drop_in = 1'b0;
        do_start();
        tests_run++;
        if (y_out !== 10'd0 || x_out !== 11'd304 || is_fixed !== 1'b0) begin
            tests_failed++;
            $display("FAIL respawn y=%0d x=%0d fix=%0b exp 0/304/0", y_out, x_out, is_fixed);
        end
        frame();
        tests_run++;
        if (x_out !== 11'd304) begin
            tests_failed++;
            $display("FAIL fixed_no_pending x=%0d exp 304", x_out);
        end
    endtask

    task automatic test_both_and_start();
        do_reset();
        do_start();
        @(negedge clk_in);
        left_in  = 1'b1;
        right_in = 1'b1;
        @(negedge clk_in);
        left_in  = 1'b0;
        right_in = 1'b0;
        frame();
        tests_run++;
        if (x_out !== 11'd304) begin
            tests_failed++;
            $display("FAIL both_buttons x=%0d exp 304", x_out);
        end
        frame();
        tests_run++;
        if (x_out !== 11'd304) begin
            tests_failed++;
            $display("FAIL both_cleared x=%0d exp 304", x_out);
        end
        press(1'b0);
        do_start();
        tests_run++;
        if (x_out !== 11'd272 || y_out !== 10'd0 || is_fixed !== 1'b0) begin
            tests_failed++;
            $display("FAIL start_falling x=%0d y=%0d fix=%0b exp 272/0/0", x_out, y_out, is_fixed);
        end
        // Counter was not cleared by start: frames so far are 3, 27 more give a step.
        for (int i = 0; i < 27; i++) frame();
        tests_run++;
        if (y_out !== 10'd32 || x_out !== 11'd272) begin
            tests_failed++;
            $display("FAIL start_falling_counter y=%0d x=%0d exp 32/272", y_out, x_out);
        end
    endtask

    task automatic test_reset_mid_fall();
        do_reset();
        do_start();
        @(negedge clk_in);
        drop_in = 1'b1;
        for (int i = 0; i < 10; i++) frame();
        tests_run++;
        if (y_out !== 10'd320) begin
            tests_failed++;
            $display("FAIL pre_reset y=%0d exp 320", y_out);
        end
        @(negedge clk_in);
        rst_in = 1'b0;
        nf_in  = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b1;
        nf_in  = 1'b0;
        tests_run++;
        if (y_out !== 10'd0 || x_out !== 11'd304 || is_fixed !== 1'b0 || landed_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_fall y=%0d x=%0d fix=%0b land=%0b exp 0/304/0/0", y_out, x_out, is_fixed, landed_out);
        end
        for (int i = 0; i < 3; i++) frame();
        tests_run++;
        if (y_out !== 10'd0) begin
            tests_failed++;
            $display("FAIL idle_after_reset y=%0d exp 0", y_out);
        end
        drop_in = 1'b0;
    endtask

    initial begin
        rst_in   = 1'b0;
        nf_in    = 1'b0;
        start_in = 1'b0;
        left_in  = 1'b0;
        right_in = 1'b0;
        drop_in  = 1'b0;
        test_reset();
        test_gravity();
        test_left_hold();
        test_clamp();
        test_drop();
        test_both_and_start();
        test_reset_mid_fall();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
